// File: rtl/vga_fb_pixel_fetch_if.sv
// Framebuffer read bus between the pixel fetch stage (master) and the BRAM (slave).
interface vga_fb_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned PIX_W  = 8
);
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd_en;
  logic [PIX_W-1:0]  fb_data;

  modport master (output fb_addr, output fb_rd_en, input fb_data);
  modport slave  (input fb_addr, input fb_rd_en, output fb_data);
endinterface

// File: rtl/vga_fb_pixel_fetch.sv
// Raster position -> 320x240 framebuffer address with 2x replication; syncs/enable delayed to match BRAM latency.
// Optional colour-bar test pattern under `VGA_TEST_PATTERN_EN (adds pattern_sel input).
module vga_fb_pixel_fetch #(
  parameter int unsigned IMG_W       = 320,
  parameter int unsigned IMG_H       = 240,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic       clk_vga,
  input  logic       reset,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       pattern_sel,
`endif
  vga_fb_pixel_fetch_if.master fb,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       frame_done
);

  localparam int unsigned LAT = RAM_LATENCY + 2;
  // Delay-line stages ahead of the output register.
  localparam int unsigned DLY = LAT - 1;

  localparam logic [9:0] H_END      = 10'd799;
  localparam logic [9:0] V_END      = 10'd524;
  localparam logic [9:0] H_LAST_VIS = 10'(2 * IMG_W - 1);
  localparam logic [9:0] V_LAST_VIS = 10'(2 * IMG_H - 1);

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_rd_en_q, fb_rd_en_d;
  logic              frame_done_q, frame_done_d;
  logic [DLY-1:0]    hs_dly_q, hs_dly_d;
  logic [DLY-1:0]    vs_dly_q, vs_dly_d;
  logic [DLY-1:0]    de_dly_q, de_dly_d;
  logic [3:0]        vga_r_q, vga_r_d;
  logic [3:0]        vga_g_q, vga_g_d;
  logic [3:0]        vga_b_q, vga_b_d;
  logic              vga_hsync_q, vga_hsync_d;
  logic              vga_vsync_q, vga_vsync_d;
  logic [3:0]        pix;
`ifdef VGA_TEST_PATTERN_EN
  logic [DLY-1:0][2:0] bar_dly_q, bar_dly_d;
  logic [DLY-1:0]      pat_dly_q, pat_dly_d;
`endif

  always_comb begin
    row_base_d = row_base_q;
    // Row base steps once per pair of lines, so no multiplier is needed.
    if (h_count == H_END) begin
      if (v_count == V_END) begin
        row_base_d = '0;
      end else if (v_count[0] && (v_count < V_LAST_VIS)) begin
        row_base_d = row_base_q + ADDR_W'(IMG_W);
      end
    end

    fb_rd_en_d   = de_in;
    fb_addr_d    = de_in ? (row_base_q + ADDR_W'(h_count[9:1])) : fb_addr_q;
    frame_done_d = (h_count == H_LAST_VIS) && (v_count == V_LAST_VIS);

    hs_dly_d    = hs_dly_q;
    vs_dly_d    = vs_dly_q;
    de_dly_d    = de_dly_q;
    hs_dly_d[0] = hsync_in;
    vs_dly_d[0] = vsync_in;
    de_dly_d[0] = de_in;
    for (int unsigned i = 1; i < DLY; i++) begin
      hs_dly_d[i] = hs_dly_q[i-1];
      vs_dly_d[i] = vs_dly_q[i-1];
      de_dly_d[i] = de_dly_q[i-1];
    end

    pix         = fb.fb_data[PIX_W-1 -: 4];
    vga_r_d     = de_dly_q[DLY-1] ? pix : '0;
    vga_g_d     = de_dly_q[DLY-1] ? pix : '0;
    vga_b_d     = de_dly_q[DLY-1] ? pix : '0;
    vga_hsync_d = hs_dly_q[DLY-1];
    vga_vsync_d = vs_dly_q[DLY-1];

`ifdef VGA_TEST_PATTERN_EN
    bar_dly_d    = bar_dly_q;
    pat_dly_d    = pat_dly_q;
    bar_dly_d[0] = h_count[8:6];
    pat_dly_d[0] = pattern_sel;
    for (int unsigned i = 1; i < DLY; i++) begin
      bar_dly_d[i] = bar_dly_q[i-1];
      pat_dly_d[i] = pat_dly_q[i-1];
    end
    if (de_dly_q[DLY-1] && pat_dly_q[DLY-1]) begin
      vga_r_d = {4{bar_dly_q[DLY-1][0]}};
      vga_g_d = {4{bar_dly_q[DLY-1][1]}};
      vga_b_d = {4{bar_dly_q[DLY-1][2]}};
    end
`endif
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      row_base_q   <= '0;
      fb_addr_q    <= '0;
      fb_rd_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      hs_dly_q     <= '1;
      vs_dly_q     <= '1;
      de_dly_q     <= '0;
      vga_r_q      <= '0;
      vga_g_q      <= '0;
      vga_b_q      <= '0;
      vga_hsync_q  <= 1'b1;
      vga_vsync_q  <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      bar_dly_q    <= '0;
      pat_dly_q    <= '0;
`endif
    end else begin
      row_base_q   <= row_base_d;
      fb_addr_q    <= fb_addr_d;
      fb_rd_en_q   <= fb_rd_en_d;
      frame_done_q <= frame_done_d;
      hs_dly_q     <= hs_dly_d;
      vs_dly_q     <= vs_dly_d;
      de_dly_q     <= de_dly_d;
      vga_r_q      <= vga_r_d;
      vga_g_q      <= vga_g_d;
      vga_b_q      <= vga_b_d;
      vga_hsync_q  <= vga_hsync_d;
      vga_vsync_q  <= vga_vsync_d;
`ifdef VGA_TEST_PATTERN_EN
      bar_dly_q    <= bar_dly_d;
      pat_dly_q    <= pat_dly_d;
`endif
    end
  end

  assign fb.fb_addr  = fb_addr_q;
  assign fb.fb_rd_en = fb_rd_en_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hsync   = vga_hsync_q;
  assign vga_vsync   = vga_vsync_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_vga_fb_pixel_fetch.sv
// Bench for vga_fb_pixel_fetch: compressed raster frames with random visible pixels, checked cycle by cycle.
module tb_vga_fb_pixel_fetch;

  localparam int IMG_W = 320;

  logic        clk_vga = 1'b0;
  logic        reset   = 1'b1;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        de_in    = 1'b0;
  logic        pattern_sel = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, frame_done;
  logic        force_ff = 1'b0;
  logic [16:0] a1;

  vga_fb_pixel_fetch_if #(.ADDR_W(17), .PIX_W(8)) fbif ();

  vga_fb_pixel_fetch #(
    .IMG_W(320), .IMG_H(240), .ADDR_W(17), .PIX_W(8), .RAM_LATENCY(2)
  ) dut (
    .clk_vga    (clk_vga),
    .reset      (reset),
    .h_count    (h_count),
    .v_count    (v_count),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .de_in      (de_in),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .fb         (fbif),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .frame_done (frame_done)
  );

  always #20 clk_vga = ~clk_vga;

  function automatic logic [7:0] mem_fn(input logic [16:0] a);
    if (a == 17'd2) return 8'hA5;
    return (a[7:0] * 8'd7) ^ a[15:8];
  endfunction

  // Two-cycle read latency BRAM: address registered, then data registered.
  always @(posedge clk_vga) begin
    a1 <= fbif.fb_addr;
    fbif.fb_data <= force_ff ? 8'hFF : mem_fn(a1);
  end

  typedef struct {
    logic [16:0] addr;
    logic        rd;
    logic        fd;
    logic        hs;
    logic        vs;
    logic [3:0]  r, g, b;
  } exp_t;

  exp_t hist[8];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   last_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int h, input int v, input bit rst_i, input bit psel);
    exp_t e;
    @(negedge clk_vga);
    reset       = rst_i;
    h_count     = 10'(h);
    v_count     = 10'(v);
    hsync_in    = !(h >= 656 && h < 752);
    vsync_in    = !(v == 490 || v == 491);
    de_in       = (h < 640) && (v < 480);
    pattern_sel = psel;
    e.addr = 17'(last_addr); e.rd = 1'b0; e.fd = 1'b0;
    e.hs = 1'b1; e.vs = 1'b1; e.r = '0; e.g = '0; e.b = '0;
    if (rst_i) begin
      last_addr = 0;
      e.addr = '0;
      for (int k = 1; k <= 3; k++) begin
        hist[(cyc + 8 - k) % 8].hs = 1'b1;
        hist[(cyc + 8 - k) % 8].vs = 1'b1;
        hist[(cyc + 8 - k) % 8].r  = '0;
        hist[(cyc + 8 - k) % 8].g  = '0;
        hist[(cyc + 8 - k) % 8].b  = '0;
      end
    end else begin
      if (de_in) begin
        last_addr = (v / 2) * IMG_W + h / 2;
        e.addr = 17'(last_addr);
        e.r = force_ff ? 4'hF : mem_fn(17'(last_addr))[7:4];
        e.g = e.r;
        e.b = e.r;
`ifdef VGA_TEST_PATTERN_EN
        if (psel) begin
          e.r = ((h >> 6) & 1) != 0 ? 4'hF : 4'h0;
          e.g = ((h >> 7) & 1) != 0 ? 4'hF : 4'h0;
          e.b = ((h >> 8) & 1) != 0 ? 4'hF : 4'h0;
        end
`endif
      end
      e.rd = de_in;
      e.fd = (h == 639) && (v == 479);
      e.hs = hsync_in;
      e.vs = vsync_in;
    end
    hist[cyc % 8] = e;
    @(posedge clk_vga);
    #1;
    chk("fb_addr",    32'(fbif.fb_addr),  32'(hist[cyc % 8].addr));
    chk("fb_rd_en",   32'(fbif.fb_rd_en), 32'(hist[cyc % 8].rd));
    chk("frame_done", 32'(frame_done),    32'(hist[cyc % 8].fd));
    chk("vga_r",      32'(vga_r),         32'(hist[(cyc + 5) % 8].r));
    chk("vga_g",      32'(vga_g),         32'(hist[(cyc + 5) % 8].g));
    chk("vga_b",      32'(vga_b),         32'(hist[(cyc + 5) % 8].b));
    chk("vga_hsync",  32'(vga_hsync),     32'(hist[(cyc + 5) % 8].hs));
    chk("vga_vsync",  32'(vga_vsync),     32'(hist[(cyc + 5) % 8].vs));
    cyc++;
  endtask

  // One compressed line: start pixels, random visible pixels, edges of blanking/sync, line end.
  task automatic run_line(input int v, input bit partial);
    int hl[$];
    for (int h = 0; h < 8; h++) hl.push_back(h);
    if (partial) begin
      hl.push_back(200);
    end else begin
      repeat (4) hl.push_back(int'($urandom_range(8, 631)));
      for (int h = 636; h <= 643; h++) hl.push_back(h);
      for (int h = 654; h <= 658; h++) hl.push_back(h);
      for (int h = 750; h <= 753; h++) hl.push_back(h);
      for (int h = 797; h <= 799; h++) hl.push_back(h);
    end
    foreach (hl[i]) step(hl[i], v, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      hist[i].addr = '0; hist[i].rd = 1'b0; hist[i].fd = 1'b0;
      hist[i].hs = 1'b1; hist[i].vs = 1'b1;
      hist[i].r = '0; hist[i].g = '0; hist[i].b = '0;
    end

    repeat (3) step(0, 0, 1'b1, 1'b0);

    for (int v = 0; v <= 524; v++) run_line(v, 1'b0);

    for (int v = 0; v < 300; v++) run_line(v, 1'b0);
    run_line(300, 1'b1);
    repeat (3) step(0, 0, 1'b1, 1'b0);

    for (int v = 0; v <= 524; v++) begin
      force_ff = (v >= 480) && (v < 524);
      run_line(v, 1'b0);
    end
    force_ff = 1'b0;

    for (int v = 0; v < 4; v++) run_line(v, 1'b0);
`ifdef VGA_TEST_PATTERN_EN
    for (int h = 0; h < 192; h++) step(h, 4, 1'b0, 1'b1);
`else
    for (int h = 0; h < 192; h++) step(h, 4, 1'b0, 1'b0);
`endif
    repeat (5) step(640, 4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
